instruction_decode: RTL
=======================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter: NREGS, 32, number of architectural registers (fixed at 32; 5-bit specifiers).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: ir2  input  32  instruction word from the fetch-stage IR2 register.
REQ-005 Port: pc2  input  32  PC+4 of ir2, from the fetch-stage PC2 register.
REQ-006 Port: wb_en  input  1  writeback enable.
REQ-007 Port: wb_addr  input  5  writeback register index.
REQ-008 Port: wb_data  input  32  writeback data.
REQ-009 Port: flush  input  1  downstream squash; forces NOP into IR3.
REQ-010 Port: ir3  output  32  registered instruction for execute.
REQ-011 Port: pc3  output  32  registered pc2.
REQ-012 Port: a3, b3  output  32 each  registered operands rs/rt.
REQ-013 Port: imm3  output  32  registered sign-extended imm[15:0].
REQ-014 Port: sel_pc  output  2  fetch PC-mux select (0=z4, 1=PC+4, 2=hold, 3=branch).
REQ-015 Port: sel_ir  output  2  fetch IR2-mux select (0=memory, 1=NOP, 2=hold).
REQ-016 Port: sel_pc2  output  1  fetch PC2-mux select (0=load, 1=hold).
REQ-017 Port: branch_address  output  32  branch target for fetch PC-mux input 3.

Function
REQ-018 Fields SHALL be: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
REQ-019 Register file SHALL have two combinational read ports (rs, rt) and one write port, written on posedge clk when wb_en=1 and wb_addr!=0.
REQ-020 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-021 Read of an index being written in the same cycle SHALL return wb_data (write-through bypass).
REQ-022 Load-use hazard SHALL be: opcode(ir3)=LW and rt(ir3)!=0 and rt(ir3) equals rs(ir2) or rt(ir2).
REQ-023 On hazard: sel_pc=2, sel_ir=2, sel_pc2=1; next ir3=NOP, a3/b3/imm3=0, pc3 unchanged; ir2 held one cycle.
REQ-024 Branch: opcode(ir2)=BEQ, no hazard, operand rs equals operand rt (post-bypass) SHALL assert taken.
REQ-025 On taken: sel_pc=3, sel_ir=1, sel_pc2=0; ir3 SHALL capture the BEQ normally.
REQ-026 branch_address SHALL be pc2 + (sext(imm)<<2), modulo 2^32, driven combinationally every cycle.
REQ-027 Otherwise: sel_pc=1, sel_ir=0, sel_pc2=0; ir3/pc3/a3/b3/imm3 capture ir2, pc2, operands, sext(imm) one cycle later.
REQ-028 flush=1 SHALL force next ir3=NOP and a3/b3/imm3=0, overriding hazard and normal capture; sel_* still follow REQ-023..027.
REQ-029 Priority SHALL be: flush (IR3 contents) > hazard > branch > normal.
REQ-030 sel_* SHALL be combinational from ir2, ir3 and register-file operands; decode latency SHALL be one cycle.

Reset
REQ-031 While rst_n=0: ir3=NOP, pc3=0, a3=b3=imm3=0, all registers 0; outputs SHALL take these values immediately, independent of clk.
REQ-032 After release, with ir3=NOP, sel_pc=1, sel_ir=0, sel_pc2=0 unless ir2 is a taken BEQ.
REQ-033 Reset asserted mid-stall SHALL cancel the stall; no held state SHALL persist.

Structure
REQ-034 Shared package SHALL hold: NOP=32'h0000_0001, opcodes LW=6'h23, BEQ=6'h04, and the sel_pc/sel_ir/sel_pc2 encodings shared with fetch.
REQ-035 Register file SHALL be a sub-module named register_file; hazard and branch logic stay in instruction_decode.

Verification
REQ-036 Reset: rst_n=0 mid-cycle -> ir3=32'h1, pc3=0, a3=b3=0 at once; after release, sel_pc=1.
REQ-037 Writeback: wb_en=1, wb_addr=5, wb_data=32'hDEAD_BEEF, same-cycle ir2 rs=5 -> a3=32'hDEAD_BEEF next cycle; wb_addr=0 write -> r0 reads 0.
REQ-038 Load-use: ir3=LW rt=7, ir2 rs=7 -> sel_pc=2, sel_ir=2, sel_pc2=1 for one cycle; next ir3=NOP; then ir2 decodes normally.
REQ-039 Branch taken: r1=r2=9, ir2=BEQ rs=1 rt=2 imm=16'hFFFE, pc2=32'h40 -> branch_address=32'h38, sel_pc=3, sel_ir=1.
REQ-040 Branch not taken: r1=9, r2=8, same ir2 -> sel_pc=1, sel_ir=0; BEQ in ir3 next cycle.
REQ-041 Flush with hazard: flush=1 and load-use same cycle -> ir3=NOP, sel_pc=2; wrap: pc2=32'hFFFF_FFFC, imm=1 -> branch_address=32'h0000_0000.

Source files
------------

// File: rtl/instruction_decode_pkg.sv
// Shared decode/fetch definitions: NOP word, opcodes and the fetch mux select encodings.
package instruction_decode_pkg;

   localparam logic [31:0] NOP    = 32'h0000_0001;
   localparam logic [5:0]  OP_LW  = 6'h23;
   localparam logic [5:0]  OP_BEQ = 6'h04;

   typedef enum logic [1:0] {
      PC_Z4     = 2'd0,
      PC_INC    = 2'd1,
      PC_HOLD   = 2'd2,
      PC_BRANCH = 2'd3
   } sel_pc_e;

   typedef enum logic [1:0] {
      IR_MEM  = 2'd0,
      IR_NOP  = 2'd1,
      IR_HOLD = 2'd2
   } sel_ir_e;

   typedef enum logic {
      PC2_LOAD = 1'b0,
      PC2_HOLD = 1'b1
   } sel_pc2_e;

   function automatic logic signed [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/register_file.sv
// Two combinational read ports, one write port; r0 is hard zero and reads see same-cycle writes.
module register_file
   import instruction_decode_pkg::*;
#(
   parameter int NREGS  = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        ra,
   input  logic [4:0]        rb,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   input  logic              we,
   input  logic [4:0]        wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [0:NREGS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   // Write-through bypass so a register written this cycle is visible to decode now.
   assign rd_a = (ra == 5'd0)           ? '0 :
                 (we && (wa == ra))     ? wd : regs[ra];
   assign rd_b = (rb == 5'd0)           ? '0 :
                 (we && (wa == rb))     ? wd : regs[rb];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: operand fetch, load-use stall, BEQ resolution and the IR3/PC3/A3/B3/IMM3 register.
module instruction_decode
   import instruction_decode_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir2,
   input  logic [31:0] pc2,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic [31:0] ir3,
   output logic [31:0] pc3,
   output logic [31:0] a3,
   output logic [31:0] b3,
   output logic [31:0] imm3,
   output logic [1:0]  sel_pc,
   output logic [1:0]  sel_ir,
   output logic        sel_pc2,
   output logic [31:0] branch_address
);

   logic [5:0]         opcode_p0;
   logic [4:0]         rs_p0;
   logic [4:0]         rt_p0;
   logic [31:0]        rs_val_p0;
   logic [31:0]        rt_val_p0;
   logic signed [31:0] imm_ext_p0;
   logic               hazard_p0;
   logic               taken_p0;
   sel_pc_e            pc_sel_p0;
   sel_ir_e            ir_sel_p0;
   sel_pc2_e           pc2_sel_p0;

   assign opcode_p0  = ir2[31:26];
   assign rs_p0      = ir2[25:21];
   assign rt_p0      = ir2[20:16];
   assign imm_ext_p0 = sext16(ir2[15:0]);

   register_file #(.NREGS(NREGS), .DATA_W(32)) u_rf (
      .clk  (clk),
      .rst_n(rst_n),
      .ra   (rs_p0),
      .rb   (rt_p0),
      .rd_a (rs_val_p0),
      .rd_b (rt_val_p0),
      .we   (wb_en),
      .wa   (wb_addr),
      .wd   (wb_data)
   );

   assign hazard_p0 = (ir3[31:26] == OP_LW) && (ir3[20:16] != 5'd0) &&
                      ((ir3[20:16] == rs_p0) || (ir3[20:16] == rt_p0));
   assign taken_p0  = (opcode_p0 == OP_BEQ) && !hazard_p0 && (rs_val_p0 == rt_val_p0);

   assign branch_address = pc2 + {imm_ext_p0[29:0], 2'b00};

   always_comb begin
      pc_sel_p0  = PC_INC;
      ir_sel_p0  = IR_MEM;
      pc2_sel_p0 = PC2_LOAD;
      if (hazard_p0) begin
         pc_sel_p0  = PC_HOLD;
         ir_sel_p0  = IR_HOLD;
         pc2_sel_p0 = PC2_HOLD;
      end else if (taken_p0) begin
         pc_sel_p0  = PC_BRANCH;
         ir_sel_p0  = IR_NOP;
      end
   end

   assign sel_pc  = pc_sel_p0;
   assign sel_ir  = ir_sel_p0;
   assign sel_pc2 = pc2_sel_p0;

   // ---- decode -> execute boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir3  <= NOP;
         pc3  <= '0;
         a3   <= '0;
         b3   <= '0;
         imm3 <= '0;
      end else begin
         if (flush || hazard_p0) begin
            ir3  <= NOP;
            a3   <= '0;
            b3   <= '0;
            imm3 <= '0;
         end else begin
            ir3  <= ir2;
            a3   <= rs_val_p0;
            b3   <= rt_val_p0;
            imm3 <= imm_ext_p0;
         end
         if (!hazard_p0) pc3 <= pc2;
      end
   end

endmodule
